// File: rtl/nvm_loader.sv
// Streams a little-endian boot image (word count, words, optional checksum) into an NVM write port.
// Optional build macro NVM_LOADER_CHECKSUM_EN enables the trailing checksum check and the error flag.
//
// state   | meaning
// IDLE    | waiting for start, CPU released
// HDR     | collecting the 4-byte word count N
// DATA    | collecting the 4 bytes of the current word
// WRITE   | single-cycle write strobe for the assembled word
// CHK     | collecting the 4-byte checksum (checksum build only)
// DONE    | single-cycle completion pulse
module nvm_loader #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      start,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      byte_ready,
  output logic                      mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_data_in,
  output logic                      cpu_hold,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  if (MEM_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("nvm_loader supports MEM_DATA_WIDTH = 32 only");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef NVM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_END   = S_CHK;
`else
  localparam logic [2:0] S_END   = S_DONE;
`endif

  logic [2:0]                state;
  logic [1:0]                byte_cnt;
  logic [31:0]               word_cnt;
  logic [31:0]               n_words;
  logic [23:0]               shreg;
  logic [31:0]               word;
  logic                      xfer;
  logic                      last_byte;
  logic                      more_words;
  logic [MEM_ADDR_WIDTH-1:0] word_off;
`ifdef NVM_LOADER_CHECKSUM_EN
  logic [31:0]               sum;
`endif

  // Bytes shift in from the top so the first byte ends up in bits 7:0.
  assign word       = {byte_data, shreg};
  assign xfer       = byte_valid & byte_ready;
  assign last_byte  = (byte_cnt == 2'd3);
  assign more_words = ({1'b0, word_cnt} + 33'd1) < {1'b0, n_words};
  assign word_off   = MEM_ADDR_WIDTH'({word_cnt, 2'b00});

  always_comb begin
    byte_ready = (state == S_HDR) || (state == S_DATA);
`ifdef NVM_LOADER_CHECKSUM_EN
    if (state == S_CHK) byte_ready = 1'b1;
`endif
  end

  assign mem_wr_en = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign cpu_hold  = (state != S_IDLE);
  assign done      = (state == S_DONE);

`ifndef NVM_LOADER_CHECKSUM_EN
  assign error = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      n_words     <= '0;
      shreg       <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
`ifdef NVM_LOADER_CHECKSUM_EN
      sum         <= '0;
      error       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HDR;
            byte_cnt <= '0;
            word_cnt <= '0;
            shreg    <= '0;
`ifdef NVM_LOADER_CHECKSUM_EN
            sum      <= '0;
            error    <= 1'b0;
`endif
          end
        end
        S_HDR: begin
          if (xfer) begin
            shreg    <= word[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              n_words <= word;
              state   <= (word != 32'd0) ? S_DATA : S_END;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            shreg    <= word[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              mem_data_in <= MEM_DATA_WIDTH'(word);
              mem_addr    <= BASE_ADDR + word_off;
`ifdef NVM_LOADER_CHECKSUM_EN
              sum         <= sum + word;
`endif
              state       <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + 32'd1;
          state    <= more_words ? S_DATA : S_END;
        end
`ifdef NVM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            shreg    <= word[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              if (word != sum) error <= 1'b1;
              state <= S_DONE;
            end
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_loader.sv
// Scoreboard bench for nvm_loader: two instances (base 0 and base 0xFFFFFFFC) share one byte stream.
// Follows NVM_LOADER_CHECKSUM_EN the same way as the design.
module tb_nvm_loader;

  logic        sys_clk = 1'b0;
  logic        sys_rst, start, byte_valid;
  logic [7:0]  byte_data;

  logic        ready_lo, wr_lo, hold_lo, busy_lo, done_lo, err_lo;
  logic [31:0] addr_lo, data_lo;
  logic        ready_hi, wr_hi, hold_hi, busy_hi, done_hi, err_hi;
  logic [31:0] addr_hi, data_hi;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          loads    = 0;
  logic [63:0] q_lo[$];
  logic [63:0] q_hi[$];
  logic        prev_wr_lo = 1'b0;
  logic        prev_wr_hi = 1'b0;
  logic [31:0] wbuf[8];

  nvm_loader #(.MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .BASE_ADDR(32'h0000_0000)) dut_lo (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready_lo), .mem_wr_en(wr_lo), .mem_addr(addr_lo),
    .mem_data_in(data_lo), .cpu_hold(hold_lo), .busy(busy_lo), .done(done_lo), .error(err_lo)
  );

  nvm_loader #(.MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .BASE_ADDR(32'hFFFF_FFFC)) dut_hi (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready_hi), .mem_wr_en(wr_hi), .mem_addr(addr_hi),
    .mem_data_in(data_hi), .cpu_hold(hold_hi), .busy(busy_hi), .done(done_hi), .error(err_hi)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitors: every strobe must match the head of its queue and last one cycle.
  always @(negedge sys_clk) begin
    if (wr_lo) begin
      check("wr_lo_single_cycle", 64'(prev_wr_lo), 64'd0);
      if (q_lo.size() == 0) check("wr_lo_unexpected", 64'(wr_lo), 64'd0);
      else check("wr_lo_addr_data", {addr_lo, data_lo}, q_lo.pop_front());
    end
    if (wr_hi) begin
      check("wr_hi_single_cycle", 64'(prev_wr_hi), 64'd0);
      if (q_hi.size() == 0) check("wr_hi_unexpected", 64'(wr_hi), 64'd0);
      else check("wr_hi_addr_data", {addr_hi, data_hi}, q_hi.pop_front());
    end
    if (done_lo) done_cnt <= done_cnt + 1;
    prev_wr_lo <= wr_lo;
    prev_wr_hi <= wr_hi;
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      if (ready_lo) begin
        @(posedge sys_clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    check("byte_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input bit mid_start);
    for (int b = 0; b < 4; b++) begin
      send_byte(w[8*b +: 8]);
      if (gaps && b < 3) begin
        if (mid_start && b == 1) start = 1'b1;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
      end
    end
  endtask

  task automatic run_load(input int n, input bit gaps, input bit mid_start, input bit bad_chk);
    logic [31:0] sum;
    logic        exp_err;
    bit          ok;
    sum = 32'd0;
    exp_err = 1'b0;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    check("busy_hold_after_start", {busy_lo, hold_lo, busy_hi, hold_hi}, 64'hF);
    check("error_cleared_by_start", {err_lo, err_hi}, 64'd0);
    send_word(32'(n), 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      q_lo.push_back({32'(i * 4), wbuf[i]});
      q_hi.push_back({32'hFFFF_FFFC + 32'(i * 4), wbuf[i]});
      sum = sum + wbuf[i];
      send_word(wbuf[i], gaps, mid_start && (i == 0));
      check("wr_latency", {wr_lo, wr_hi}, 64'd3);
    end
`ifdef NVM_LOADER_CHECKSUM_EN
    exp_err = bad_chk;
    send_word(bad_chk ? sum + 32'd1 : sum, 1'b0, 1'b0);
`else
    exp_err = 1'b0;
    if (bad_chk) exp_err = 1'b0;
`endif
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (done_lo) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(ok), 64'd1);
    check("done_both", 64'(done_hi), 64'd1);
    check("error_at_done", {err_lo, err_hi}, {62'd0, exp_err, exp_err});
    @(negedge sys_clk);
    loads++;
    check("after_done", {done_lo, busy_lo, hold_lo, err_lo}, {60'd0, 3'b000, exp_err});
    check("done_count", 64'(done_cnt), 64'(loads));
    check("writes_outstanding", 64'(q_lo.size() + q_hi.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {ready_lo, wr_lo, hold_lo, busy_lo, done_lo, err_lo,
                ready_hi, wr_hi, hold_hi, busy_hi, done_hi, err_hi}, 64'd0);
    check({tag, "_lo_bus"}, {addr_lo, data_lo}, 64'd0);
    check({tag, "_hi_bus"}, {addr_hi, data_hi}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check_reset_outputs("reset_values");

    // Basic two-word image
    wbuf[0] = 32'h1122_3344;
    wbuf[1] = 32'hA5A5_A5A5;
    run_load(2, 1'b0, 1'b0, 1'b0);

    // Empty image
    run_load(0, 1'b0, 1'b0, 1'b0);

    // Bad checksum: sticky error, then cleared by the next start
    wbuf[0] = 32'h0000_0001;
    run_load(1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge sys_clk);
    #1;
    check("error_sticky_idle", {err_lo, busy_lo}, {62'd0, 1'b`ifdef NVM_LOADER_CHECKSUM_EN 1 `else 0 `endif, 1'b0});

    // Gappy byte stream with an ignored start mid-load
    wbuf[0] = 32'h1122_3344;
    wbuf[1] = 32'hA5A5_A5A5;
    run_load(2, 1'b1, 1'b1, 1'b0);

    // Reset after two data bytes of the first word
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    send_word(32'd2, 1'b0, 1'b0);
    send_byte(8'h44);
    send_byte(8'h33);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check_reset_outputs("reset_mid_word");
    repeat (4) @(posedge sys_clk);
    #1;
    check("no_write_after_reset", {busy_lo, wr_lo}, 64'd0);

    // A fresh load after reset, random words
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    run_load(3, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
